// File: rtl/trap_sequencer.sv
// Trap/mret sequencer: arbitrates F/E exceptions and mret, commits the winner to the CSR unit,
// flushes the pipeline for a fixed drain period, then issues one PC redirect.
module trap_sequencer #(
    parameter logic [1:0] XLEN         = 2'b10,
    parameter logic [3:0] NONE_CODE    = 4'hF,
    parameter int         DRAIN_CYCLES = 3,
    localparam int        W            = 1 << (XLEN + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clk_en,
    input  logic         i_exc_valid_f,
    input  logic [3:0]   i_exc_code_f,
    input  logic [W-1:0] i_exc_pc_f,
    input  logic         i_exc_valid_e,
    input  logic [3:0]   i_exc_code_e,
    input  logic [W-1:0] i_exc_pc_e,
    input  logic [W-1:0] i_exc_addr_e,
    input  logic         i_mret_e,
    input  logic [W-1:0] i_mtvec,
    input  logic [W-1:0] i_mepc,
    output logic [3:0]   o_exception_code_f,
    output logic [W-1:0] o_exception_pc_f,
    output logic [3:0]   o_exception_code_e,
    output logic [W-1:0] o_exception_pc_e,
    output logic [W-1:0] o_exception_addr_e,
    output logic         o_mret_e,
    output logic         o_stall,
    output logic         o_flush,
    output logic         o_redirect_valid,
    output logic [W-1:0] o_redirect_pc
);

    typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_DRAIN, S_REDIRECT} state_t;
    typedef enum logic [1:0] {EV_F, EV_E, EV_MRET} ev_t;

    localparam logic [3:0]   DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [W-1:0] MODE_MASK  = ~W'(3);

    state_t       state_q, state_d;
    ev_t          ev_q, ev_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   code_q, code_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] addr_q, addr_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            ev_q    <= EV_F;
            cnt_q   <= '0;
            code_q  <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ev_q    <= ev_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ev_d    = ev_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        if (i_clk_en) begin
            case (state_q)
                S_IDLE: begin
                    // Execute beats mret beats fetch; losers are refetched after the flush.
                    if (i_exc_valid_e) begin
                        state_d = S_COMMIT;
                        ev_d    = EV_E;
                        code_d  = i_exc_code_e;
                        pc_d    = i_exc_pc_e;
                        addr_d  = i_exc_addr_e;
                    end else if (i_mret_e) begin
                        state_d = S_COMMIT;
                        ev_d    = EV_MRET;
                        code_d  = NONE_CODE;
                        pc_d    = '0;
                        addr_d  = '0;
                    end else if (i_exc_valid_f) begin
                        state_d = S_COMMIT;
                        ev_d    = EV_F;
                        code_d  = i_exc_code_f;
                        pc_d    = i_exc_pc_f;
                        addr_d  = '0;
                    end
                end
                S_COMMIT: begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
                S_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = S_REDIRECT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_REDIRECT: state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_exception_code_f = NONE_CODE;
        o_exception_pc_f   = '0;
        o_exception_code_e = NONE_CODE;
        o_exception_pc_e   = '0;
        o_exception_addr_e = '0;
        o_mret_e           = 1'b0;
        o_stall            = (state_q != S_IDLE);
        o_flush            = (state_q == S_COMMIT) || (state_q == S_DRAIN);
        o_redirect_valid   = (state_q == S_REDIRECT);
        o_redirect_pc      = '0;
        if (state_q == S_COMMIT) begin
            case (ev_q)
                EV_E: begin
                    o_exception_code_e = code_q;
                    o_exception_pc_e   = pc_q;
                    o_exception_addr_e = addr_q;
                end
                EV_MRET: o_mret_e = 1'b1;
                default: begin
                    o_exception_code_f = code_q;
                    o_exception_pc_f   = pc_q;
                end
            endcase
        end
        // CSR values are read live here so the commit's own update is already visible.
        if (state_q == S_REDIRECT) begin
            o_redirect_pc = (ev_q == EV_MRET) ? i_mepc : (i_mtvec & MODE_MASK);
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: per-cycle vector table plus hand-written reset sequences.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        vf, ve, mret;
    logic [3:0]  cf, ce;
    logic [63:0] pcf, pce, ae;
    logic [63:0] mtvec, mepc;
    logic [3:0]  o_cf, o_ce;
    logic [63:0] o_pcf, o_pce, o_ae, o_rpc;
    logic        o_mret, o_stall, o_flush, o_rv;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    trap_sequencer #(.XLEN(2'b10), .NONE_CODE(4'hF), .DRAIN_CYCLES(3)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_clk_en(en),
        .i_exc_valid_f(vf), .i_exc_code_f(cf), .i_exc_pc_f(pcf),
        .i_exc_valid_e(ve), .i_exc_code_e(ce), .i_exc_pc_e(pce), .i_exc_addr_e(ae),
        .i_mret_e(mret), .i_mtvec(mtvec), .i_mepc(mepc),
        .o_exception_code_f(o_cf), .o_exception_pc_f(o_pcf),
        .o_exception_code_e(o_ce), .o_exception_pc_e(o_pce), .o_exception_addr_e(o_ae),
        .o_mret_e(o_mret), .o_stall(o_stall), .o_flush(o_flush),
        .o_redirect_valid(o_rv), .o_redirect_pc(o_rpc)
    );

    typedef struct {
        int          tst;
        logic        en, vf, ve, mret;
        logic [3:0]  cf, ce;
        logic [63:0] pcf, pce, ae;
        logic [3:0]  x_cf, x_ce;
        logic        x_mret, x_stall, x_flush, x_rv;
        logic [63:0] x_pcf, x_pce, x_ae, x_rpc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t base(int t);
        vec_t v;
        v.tst = t; v.en = 1'b1; v.vf = 1'b0; v.ve = 1'b0; v.mret = 1'b0;
        v.cf = 4'h0; v.ce = 4'h0; v.pcf = '0; v.pce = '0; v.ae = '0;
        v.x_cf = 4'hF; v.x_ce = 4'hF; v.x_mret = 1'b0;
        v.x_stall = 1'b0; v.x_flush = 1'b0; v.x_rv = 1'b0;
        v.x_pcf = '0; v.x_pce = '0; v.x_ae = '0; v.x_rpc = '0;
        return v;
    endfunction

    function automatic vec_t drain(int t);
        vec_t v = base(t);
        v.x_stall = 1'b1; v.x_flush = 1'b1;
        return v;
    endfunction

    function automatic vec_t redir(int t, logic [63:0] pc);
        vec_t v = base(t);
        v.x_stall = 1'b1; v.x_rv = 1'b1; v.x_rpc = pc;
        return v;
    endfunction

    function automatic vec_t fcommit(int t, logic [3:0] c, logic [63:0] pc);
        vec_t v = drain(t);
        v.vf = 1'b1; v.cf = c; v.pcf = pc; v.x_cf = c; v.x_pcf = pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [267:0] act, input logic [267:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [267:0] outs();
        return {o_cf, o_ce, o_mret, o_stall, o_flush, o_rv, o_pcf, o_pce, o_ae, o_rpc};
    endfunction

    initial begin
        vec_t r;
        logic saw_rv;

        // Test 2: fetch trap, mtvec mode bits dropped from the redirect target.
        tbl.push_back(fcommit(2, 4'h1, 64'h100));
        for (int k = 0; k < 3; k++) tbl.push_back(drain(2));
        tbl.push_back(redir(2, 64'h8000_0000));
        tbl.push_back(base(2));
        // Test 3: all three events together, execute wins.
        r = drain(3);
        r.ve = 1'b1; r.ce = 4'hB; r.pce = 64'h200; r.ae = 64'h1234;
        r.vf = 1'b1; r.cf = 4'h2; r.pcf = 64'h180; r.mret = 1'b1;
        r.x_ce = 4'hB; r.x_pce = 64'h200; r.x_ae = 64'h1234;
        tbl.push_back(r);
        for (int k = 0; k < 3; k++) tbl.push_back(drain(3));
        tbl.push_back(redir(3, 64'h8000_0000));
        tbl.push_back(base(3));
        // Test 4: mret beats a same-cycle fetch trap, redirects to mepc.
        r = drain(4); r.mret = 1'b1; r.vf = 1'b1; r.cf = 4'h3; r.x_mret = 1'b1;
        tbl.push_back(r);
        for (int k = 0; k < 3; k++) tbl.push_back(drain(4));
        tbl.push_back(redir(4, 64'h300));
        tbl.push_back(base(4));
        // Test 5: execute exception during drain and redirect is ignored.
        tbl.push_back(fcommit(5, 4'h3, 64'h500));
        for (int k = 0; k < 3; k++) begin
            r = drain(5); r.ve = 1'b1; r.ce = 4'hB; r.pce = 64'h600; tbl.push_back(r);
        end
        r = redir(5, 64'h8000_0000); r.ve = 1'b1; r.ce = 4'hB; tbl.push_back(r);
        tbl.push_back(base(5));
        tbl.push_back(base(5));
        // Test 6: enable low two cycles in drain delays the redirect by two.
        tbl.push_back(fcommit(6, 4'h4, 64'h700));
        tbl.push_back(drain(6));
        for (int k = 0; k < 2; k++) begin
            r = drain(6); r.en = 1'b0; tbl.push_back(r);
        end
        tbl.push_back(drain(6));
        tbl.push_back(drain(6));
        tbl.push_back(redir(6, 64'h8000_0000));
        // Enable low during redirect extends the pulse rather than repeating it.
        r = redir(6, 64'h8000_0000); r.en = 1'b0; tbl.push_back(r);
        tbl.push_back(base(6));
        // Enable low in idle: an event is not sampled.
        r = base(7); r.en = 1'b0; r.vf = 1'b1; r.cf = 4'h6; tbl.push_back(r);
        tbl.push_back(base(7));

        // Test 1: reset with events driven.
        rst_n = 1'b0; en = 1'b1; vf = 1'b1; ve = 1'b1; mret = 1'b1;
        cf = 4'h1; ce = 4'h2; pcf = 64'h10; pce = 64'h20; ae = 64'h30;
        mtvec = 64'h8000_0001; mepc = 64'h300;
        repeat (2) @(posedge clk);
        #1;
        check("reset_codes", {260'd0, o_cf, o_ce}, {260'd0, 4'hF, 4'hF});
        check("reset_ctrl", {264'd0, o_mret, o_stall, o_flush, o_rv}, 268'd0);
        check("reset_paths", {12'd0, o_pcf, o_pce, o_ae, o_rpc}, 268'd0);
        vf = 1'b0; ve = 1'b0; mret = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", outs(), {4'hF, 4'hF, 4'b0000, 256'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en; vf = tbl[i].vf; ve = tbl[i].ve; mret = tbl[i].mret;
            cf = tbl[i].cf; ce = tbl[i].ce; pcf = tbl[i].pcf; pce = tbl[i].pce; ae = tbl[i].ae;
            @(posedge clk);
            #1;
            $display("vec %0d test %0d: stall=%0b flush=%0b rv=%0b rpc=%h", i, tbl[i].tst,
                     o_stall, o_flush, o_rv, o_rpc);
            check($sformatf("t%0d_row%0d", tbl[i].tst, i), outs(),
                  {tbl[i].x_cf, tbl[i].x_ce, tbl[i].x_mret, tbl[i].x_stall, tbl[i].x_flush,
                   tbl[i].x_rv, tbl[i].x_pcf, tbl[i].x_pce, tbl[i].x_ae, tbl[i].x_rpc});
        end

        // Async reset in the middle of drain: immediate reset outputs, no redirect afterwards.
        en = 1'b1; vf = 1'b1; cf = 4'h5; pcf = 64'h400; ve = 1'b0; mret = 1'b0;
        @(posedge clk);
        #1;
        vf = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_drain", {266'd0, o_stall, o_flush}, {266'd0, 2'b11});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", outs(), {4'hF, 4'hF, 4'b0000, 256'd0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_rv = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (o_rv || o_stall) saw_rv = 1'b1;
        end
        $display("post-reset window: redirect/stall seen=%0b", saw_rv);
        check("no_redirect_after_reset", {267'd0, saw_rv}, 268'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
